// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : mux4_rr_arbiter
// Description: Round-robin arbiter/sequencer for a shared 4:1 data mux.
//              Grants one requester at a time, drives the mux select
//              (s1,s0), presents the selected word on a valid/ready port and
//              limits each grant to MAX_BURST accepted beats, followed by one
//              IDLE bubble cycle.
//              Optional feature macro: MUX4_ARB_FIXED_PRIO_EN
//              (lowest-numbered requester always wins instead of rotating).
// Revision   : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic [3:0]        gnt,
  output logic              s1,
  output logic              s0,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Count value of the final beat allowed in one grant.
  localparam logic [3:0] c_last_beat = 4'(MAX_BURST - 1);

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic [1:0] r_last;
  logic [3:0] r_count;

  state_t     w_nxt_state;
  logic [3:0] w_nxt_gnt;
  logic [1:0] w_nxt_sel;
  logic [1:0] w_nxt_last;
  logic [3:0] w_nxt_count;
  logic [1:0] w_pick;
  logic       w_accept;

  assign gnt = r_gnt;
  assign s1  = r_sel[1];
  assign s0  = r_sel[0];

  // Mux is unqualified: dout follows the select regardless of valid.
  assign dout = r_sel[1] ? (r_sel[0] ? din3 : din2)
                         : (r_sel[0] ? din1 : din0);

  assign dout_valid = (r_state == BUSY) && req[r_sel];
  assign w_accept   = dout_valid && dout_ready;

`ifdef MUX4_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from high to low so channel 0 ends up winning.
  always_comb begin
    w_pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) w_pick = 2'(i);
    end
  end
`else
  // Round robin: scan offsets last+4 .. last+1 so the nearest one after the
  // last winner overrides the others.
  always_comb begin
    w_pick = r_last + 2'd1;
    for (int i = 4; i >= 1; i--) begin
      if (req[r_last + 2'(i)]) w_pick = r_last + 2'(i);
    end
  end
`endif

  // Next-state and next-register computation for the IDLE/BUSY sequencer.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gnt   = r_gnt;
    w_nxt_sel   = r_sel;
    w_nxt_last  = r_last;
    w_nxt_count = r_count;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_nxt_state = BUSY;
          w_nxt_gnt   = 4'b0001 << w_pick;
          w_nxt_sel   = w_pick;
          w_nxt_last  = w_pick;
          w_nxt_count = 4'd0;
        end
      end
      BUSY: begin
        if (w_accept) begin
          // The final beat is not counted past c_last_beat; the grant ends.
          if (r_count == c_last_beat) begin
            w_nxt_state = IDLE;
            w_nxt_gnt   = 4'd0;
            w_nxt_count = 4'd0;
          end else begin
            w_nxt_count = r_count + 4'd1;
          end
        end else if (!req[r_sel]) begin
          // Requester withdrew; select is left where it was.
          w_nxt_state = IDLE;
          w_nxt_gnt   = 4'd0;
          w_nxt_count = 4'd0;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_gnt   = 4'd0;
      end
    endcase
  end

  // State and output registers; pointer resets to 3 so channel 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= 4'd0;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_count <= 4'd0;
    end else begin
      r_state <= w_nxt_state;
      r_gnt   <= w_nxt_gnt;
      r_sel   <= w_nxt_sel;
      r_last  <= w_nxt_last;
      r_count <= w_nxt_count;
    end
  end

endmodule
`default_nettype wire
